// File: rtl/pc_fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its surroundings: PC register
// write port, instruction-memory request/response, decode handshake and the
// branch redirect. The controller takes the master side.
interface pc_fetch_ctrl_if;
  logic [15:0] pc_cur;
  logic [15:0] pc_next;
  logic        pc_wen;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halted;

  modport master (
    input  pc_cur, imem_valid, imem_data, instr_ready, br_taken, br_target,
    output pc_next, pc_wen, imem_req, imem_addr, instr_out, instr_valid, halted
  );

  modport slave (
    output pc_cur, imem_valid, imem_data, instr_ready, br_taken, br_target,
    input  pc_next, pc_wen, imem_req, imem_addr, instr_out, instr_valid, halted
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: one memory request per instruction, decode
// handshake on the returned word, then a PC write of PC+2 or a branch target.
// A HLT opcode stops fetching until reset.
module pc_fetch_ctrl #(
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_REDIR,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc_next;
  logic        r_pc_wen;
  logic [15:0] r_instr_out;
  logic        r_instr_valid;
  logic        r_halted;
  logic        r_redir_pend;
  logic [15:0] r_tgt;
  logic        r_hlt_flag;

  logic        w_is_hlt;
  logic [15:0] w_pc_inc;

  assign w_is_hlt = (bus.imem_data[15:12] == HLT_OP);
  assign w_pc_inc = bus.pc_cur + 16'd2;

  // The request is a state decode; it is held off while reset is asserted so
  // a long reset still yields a single request once it releases.
  assign bus.imem_req    = (r_state == S_FETCH) && !rst;
  assign bus.imem_addr   = bus.pc_cur;
  assign bus.pc_next     = r_pc_next;
  assign bus.pc_wen      = r_pc_wen;
  assign bus.instr_out   = r_instr_out;
  assign bus.instr_valid = r_instr_valid;
  assign bus.halted      = r_halted;

  // Fetch state machine with registered outputs; a branch pulse overrides the
  // normal PC+2 path and any handshake completing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc_next     <= 16'h0000;
      r_pc_wen      <= 1'b0;
      r_instr_out   <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_redir_pend  <= 1'b0;
      r_tgt         <= 16'h0000;
      r_hlt_flag    <= 1'b0;
    end else begin
      if (bus.br_taken && (r_state != S_HALT)) begin
        r_tgt <= bus.br_target;
      end
      case (r_state)
        S_FETCH: begin
          r_pc_wen <= 1'b0;
          if (bus.br_taken) begin
            r_redir_pend <= 1'b1;
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_valid && (bus.br_taken || r_redir_pend)) begin
            // Response belongs to a squashed path: drop it and redirect.
            r_pc_next    <= bus.br_taken ? bus.br_target : r_tgt;
            r_pc_wen     <= 1'b1;
            r_redir_pend <= 1'b0;
            r_state      <= S_REDIR;
          end else if (bus.br_taken) begin
            r_redir_pend <= 1'b1;
          end else if (bus.imem_valid) begin
            r_instr_out   <= bus.imem_data;
            r_instr_valid <= 1'b1;
            if (w_is_hlt) begin
              r_hlt_flag <= 1'b1;
            end else begin
              r_pc_next <= w_pc_inc;
              r_pc_wen  <= 1'b1;
            end
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.br_taken) begin
            r_instr_valid <= 1'b0;
            r_hlt_flag    <= 1'b0;
            r_pc_next     <= bus.br_target;
            r_pc_wen      <= 1'b1;
            r_redir_pend  <= 1'b0;
            r_state       <= S_REDIR;
          end else begin
            r_pc_wen <= 1'b0;
            if (bus.instr_ready) begin
              r_instr_valid <= 1'b0;
              if (r_hlt_flag) begin
                r_halted <= 1'b1;
                r_state  <= S_HALT;
              end else begin
                r_state <= S_FETCH;
              end
            end
          end
        end
        S_REDIR: begin
          if (bus.br_taken) begin
            // A newer target replaces the one being written; stay one more cycle.
            r_pc_next <= bus.br_target;
            r_pc_wen  <= 1'b1;
          end else begin
            r_pc_wen <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        S_HALT: begin
          r_pc_wen <= 1'b0;
        end
        default: begin
          r_pc_wen <= 1'b0;
          r_state  <= S_FETCH;
        end
      endcase
    end
  end

endmodule
